// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared state encoding and default widths for the TDC hit packer
package tdc_pkg;
  localparam int TOF_W_DEF  = 15;
  localparam int SPAD_N_DEF = 16;
  localparam int INT_W_DEF  = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CAPTURE = 2'd1;
  localparam state_t ST_SEND    = 2'd2;

  // Stored in place of a TOF that lies beyond the sampled range.
  localparam logic [TOF_W_DEF-1:0] TOF_OVF = '1;
endpackage

// File: rtl/tdc_hit_packer_if.sv
// rtl/tdc_hit_packer_if.sv - one-beat-per-hit stream from the packer to the core-logic consumer
interface tdc_hit_packer_if
  import tdc_pkg::*;
#(
  parameter int TOF_W = TOF_W_DEF,
  parameter int INT_W = INT_W_DEF,
  parameter int NUM_W = 2
);
  logic [TOF_W-1:0] TDC_Odata;
  logic [INT_W-1:0] TDC_Oint;
  logic [NUM_W-1:0] TDC_Onum;
  logic             TDC_Olast;
  logic             TDC_Ovalid;
  logic             TDC_Oready;

  modport master (
    output TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid,
    input  TDC_Oready
  );

  modport slave (
    input  TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid,
    output TDC_Oready
  );
endinterface

// File: rtl/tdc_popcount.sv
// rtl/tdc_popcount.sv - SPAD enable popcount saturated to an intensity code
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int SPAD_N = SPAD_N_DEF,
  parameter int INT_W  = INT_W_DEF
) (
  input  logic [SPAD_N-1:0] spad,
  output logic [INT_W-1:0]  code
);
  localparam int CW   = $clog2(SPAD_N + 1);
  localparam int MAXV = (1 << INT_W) - 1;

  logic [CW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < SPAD_N; i++) begin
      ones = ones + CW'(spad[i]);
    end
    code = (int'(ones) > MAXV) ? INT_W'(MAXV) : INT_W'(ones);
  end
endmodule

// File: rtl/tdc_hit_packer.sv
// rtl/tdc_hit_packer.sv - per-frame multi-hit buffer streamed out as one beat per hit
// TDC_EMPTY_FRAME_EN: a frame closed with no hits still emits one zero beat marked last.
module tdc_hit_packer
  import tdc_pkg::*;
#(
  parameter int MAX_HITS = 3,
  parameter int TOF_W    = TOF_W_DEF,
  parameter int SPAD_N   = SPAD_N_DEF,
  parameter int INT_W    = INT_W_DEF,
  parameter int NUM_W    = $clog2(MAX_HITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic [TOF_W-1:0]  range,
  input  logic              hit_valid,
  input  logic [TOF_W-1:0]  hit_tof,
  input  logic [SPAD_N-1:0] hit_spad,
  tdc_hit_packer_if.master  tx,
  output logic              TDC_INT,
  output logic [7:0]        drop_cnt
);
  localparam int IW = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1;
  localparam logic [NUM_W-1:0] FULL = NUM_W'(MAX_HITS);

  state_t           state;
  logic [NUM_W-1:0] count;
  logic [NUM_W-1:0] beat;
  logic [NUM_W-1:0] count_nxt;
  logic [TOF_W-1:0] slot_tof [MAX_HITS];
  logic [INT_W-1:0] slot_int [MAX_HITS];
  logic [INT_W-1:0] hit_int;
  logic [TOF_W-1:0] hit_tof_clip;
  logic             store;
  logic             sending;
  logic             last_beat;
  logic             drop_inc;

  tdc_popcount #(.SPAD_N(SPAD_N), .INT_W(INT_W)) u_popcount (
    .spad (hit_spad),
    .code (hit_int)
  );

  assign hit_tof_clip = (hit_tof <= range) ? hit_tof : '1;
  assign store        = (state == ST_CAPTURE) && hit_valid && (count < FULL);
  assign count_nxt    = store ? count + 1'b1 : count;
  assign sending      = (state == ST_SEND);
  // An empty frame (count 0) is its own last beat.
  assign last_beat    = sending && ((count == '0) || (beat == count - 1'b1));
  assign drop_inc     = frame_start && (((state == ST_CAPTURE) && frame_end) || sending);

  assign tx.TDC_Ovalid = sending;
  assign tx.TDC_Olast  = last_beat;
  assign tx.TDC_Onum   = sending ? count : '0;
  assign tx.TDC_Odata  = (sending && (count != '0)) ? slot_tof[IW'(beat)] : '0;
  assign tx.TDC_Oint   = (sending && (count != '0)) ? slot_int[IW'(beat)] : '0;
  assign TDC_INT       = sending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      beat     <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < MAX_HITS; i++) begin
        slot_tof[i] <= '0;
        slot_int[i] <= '0;
      end
    end else begin
      if (store) begin
        slot_tof[IW'(count)] <= hit_tof_clip;
        slot_int[IW'(count)] <= hit_int;
      end
      if (drop_inc && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_CAPTURE;
            count <= '0;
          end
        end
        ST_CAPTURE: begin
          count <= count_nxt;
          if (frame_end) begin
            beat <= '0;
`ifdef TDC_EMPTY_FRAME_EN
            state <= ST_SEND;
`else
            state <= (count_nxt != '0) ? ST_SEND : ST_IDLE;
`endif
          end else if (frame_start) begin
            count <= '0;
          end
        end
        ST_SEND: begin
          if (tx.TDC_Oready) begin
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdc_hit_packer.sv
// tb/tb_tdc_hit_packer.sv - self-checking bench for tdc_hit_packer
module tb_tdc_hit_packer;
  localparam int MAX_HITS = 3;
  localparam int TOF_W    = 15;
  localparam int SPAD_N   = 16;
  localparam int INT_W    = 4;
  localparam int NUM_W    = 2;

  typedef struct packed {
    logic [14:0] tof;
    logic [3:0]  intc;
    logic [1:0]  num;
    logic        last;
  } beat_t;

  typedef struct {
    logic [14:0] tof;
    logic [15:0] spad;
    logic [14:0] rng;
    logic [14:0] e_tof;
    logic [3:0]  e_int;
  } vec_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        frame_start = 0;
  logic        frame_end = 0;
  logic        hit_valid = 0;
  logic [14:0] range = 0;
  logic [14:0] hit_tof = 0;
  logic [15:0] hit_spad = 0;
  logic        TDC_INT;
  logic [7:0]  drop_cnt;

  int    checks = 0;
  int    failures = 0;
  bit    rnd_ready = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  beat_t hits_q[$];
  vec_t  vecs[7];

  tdc_hit_packer_if #(.TOF_W(TOF_W), .INT_W(INT_W), .NUM_W(NUM_W)) bus ();

  tdc_hit_packer #(
    .MAX_HITS(MAX_HITS), .TOF_W(TOF_W), .SPAD_N(SPAD_N), .INT_W(INT_W), .NUM_W(NUM_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .range       (range),
    .hit_valid   (hit_valid),
    .hit_tof     (hit_tof),
    .hit_spad    (hit_spad),
    .tx          (bus),
    .TDC_INT     (TDC_INT),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.TDC_Oready = 1'($urandom_range(0, 1));
  endtask

  // Reference: each hit reduces to (clipped TOF, saturated popcount); a closed frame
  // yields its first MAX_HITS hits in order, all carrying the kept count.
  function automatic beat_t mk_hit(logic [14:0] tof, logic [15:0] spad, logic [14:0] rng);
    beat_t b;
    int pc = $countones(spad);
    b.tof  = (tof <= rng) ? tof : 15'h7FFF;
    b.intc = (pc > 15) ? 4'd15 : 4'(pc);
    b.num  = 2'd0;
    b.last = 1'b0;
    return b;
  endfunction

  function automatic void close_frame();
    int k = (hits_q.size() > MAX_HITS) ? MAX_HITS : hits_q.size();
    for (int i = 0; i < k; i++) begin
      beat_t b;
      b = hits_q[i];
      b.num  = 2'(k);
      b.last = (i == k - 1);
      exp_q.push_back(b);
    end
`ifdef TDC_EMPTY_FRAME_EN
    if (k == 0) exp_q.push_back('{tof: 15'd0, intc: 4'd0, num: 2'd0, last: 1'b1});
`endif
    hits_q.delete();
  endfunction

  task automatic fstart();
    frame_start = 1;
    step();
    frame_start = 0;
  endtask

  task automatic hit(input logic [14:0] tof, input logic [15:0] spad, input bit with_end);
    hit_valid = 1;
    hit_tof   = tof;
    hit_spad  = spad;
    frame_end = with_end;
    hits_q.push_back(mk_hit(tof, spad, range));
    step();
    hit_valid = 0;
    frame_end = 0;
    if (with_end) close_frame();
  endtask

  task automatic fend();
    frame_end = 1;
    step();
    frame_end = 0;
    close_frame();
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (bus.TDC_Ovalid && c < 100) begin
      step();
      c++;
    end
    chk({name, "_drain_timeout"}, 32'(c >= 100), 0);
  endtask

  task automatic cmp_stream(input string name);
    chk({name, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_beat%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Stream monitor: records handshaken beats and holds stalled beats to stability.
  beat_t prev;
  beat_t cur;
  bit    prev_stall = 0;
  always @(negedge clk) begin
    cur = '{tof: bus.TDC_Odata, intc: bus.TDC_Oint, num: bus.TDC_Onum, last: bus.TDC_Olast};
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.TDC_Ovalid), 1);
        chk("stall_stable", 32'(cur), 32'(prev));
      end
      if (bus.TDC_Ovalid && bus.TDC_Oready) got_q.push_back(cur);
      prev_stall = bus.TDC_Ovalid && !bus.TDC_Oready;
      prev = cur;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    bit    co;
    bit    pat[5];
    vecs[0] = '{15'd100,   16'h000F, 15'd500,   15'd100,   4'd4};
    vecs[1] = '{15'd600,   16'h0001, 15'd500,   15'h7FFF,  4'd1};
    vecs[2] = '{15'd500,   16'hFFFF, 15'd500,   15'd500,   4'd15};
    vecs[3] = '{15'd501,   16'h0000, 15'd500,   15'h7FFF,  4'd0};
    vecs[4] = '{15'd0,     16'h8001, 15'd0,     15'd0,     4'd2};
    vecs[5] = '{15'h7FFF,  16'h7FFF, 15'h7FFF,  15'h7FFF,  4'd15};
    vecs[6] = '{15'd123,   16'hFFFE, 15'h7FFF,  15'd123,   4'd15};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.TDC_Oready = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.TDC_Ovalid), 0);
    chk("rst_data", 32'(bus.TDC_Odata), 0);
    chk("rst_int", 32'(bus.TDC_Oint), 0);
    chk("rst_num", 32'(bus.TDC_Onum), 0);
    chk("rst_last", 32'(bus.TDC_Olast), 0);
    chk("rst_irq", 32'(TDC_INT), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst_n = 1;
    step();

    // Single-hit frames with the hit coincident with frame_end.
    for (int i = 0; i < 7; i++) begin
      fstart();
      range     = vecs[i].rng;
      hit_valid = 1;
      hit_tof   = vecs[i].tof;
      hit_spad  = vecs[i].spad;
      frame_end = 1;
      step();
      hit_valid = 0;
      frame_end = 0;
      chk($sformatf("vec%0d_data", i), 32'(bus.TDC_Odata), 32'(vecs[i].e_tof));
      chk($sformatf("vec%0d_int", i), 32'(bus.TDC_Oint), 32'(vecs[i].e_int));
      chk($sformatf("vec%0d_num", i), 32'(bus.TDC_Onum), 1);
      chk($sformatf("vec%0d_last", i), 32'(bus.TDC_Olast), 1);
      drain("vec");
      got_q.delete();
    end

    // Two-hit frame, cycle-exact.
    range = 15'd1000;
    fstart();
    hit(15'd100, 16'h000F, 0);
    hit(15'd200, 16'hFFFF, 0);
    fend();
    chk("two_valid0", 32'(bus.TDC_Ovalid), 1);
    chk("two_irq0", 32'(TDC_INT), 1);
    chk("two_data0", 32'(bus.TDC_Odata), 100);
    chk("two_int0", 32'(bus.TDC_Oint), 4);
    chk("two_num0", 32'(bus.TDC_Onum), 2);
    chk("two_last0", 32'(bus.TDC_Olast), 0);
    step();
    chk("two_data1", 32'(bus.TDC_Odata), 200);
    chk("two_int1", 32'(bus.TDC_Oint), 15);
    chk("two_num1", 32'(bus.TDC_Onum), 2);
    chk("two_last1", 32'(bus.TDC_Olast), 1);
    chk("two_irq1", 32'(TDC_INT), 1);
    step();
    chk("two_valid_end", 32'(bus.TDC_Ovalid), 0);
    chk("two_irq_end", 32'(TDC_INT), 0);
    cmp_stream("two");

    // Overflow and discard of the fourth hit.
    range = 15'd500;
    fstart();
    hit(15'd10, 16'h0003, 0);
    hit(15'd600, 16'h0007, 0);
    hit(15'd20, 16'h00FF, 0);
    hit(15'd30, 16'h0001, 0);
    fend();
    drain("ovf");
    chk("ovf_tof", 32'(got_q[1].tof), 32'h7FFF);
    cmp_stream("ovf");

    // Backpressure 1,0,0,1,1.
    fstart();
    hit(15'd1, 16'h0001, 0);
    hit(15'd2, 16'h0003, 0);
    hit(15'd3, 16'h0007, 0);
    bus.TDC_Oready = 0;
    fend();
    for (int i = 0; i < 5; i++) begin
      bus.TDC_Oready = pat[i];
      step();
    end
    chk("bp_done", 32'(bus.TDC_Ovalid), 0);
    chk("bp_hs", got_q.size(), 3);
    cmp_stream("bp");

    // frame_start during SEND, then frame_start with frame_end in CAPTURE.
    bus.TDC_Oready = 0;
    fstart();
    hit(15'd40, 16'h00F0, 0);
    hit(15'd50, 16'h0F00, 0);
    fend();
    frame_start = 1;
    step();
    frame_start = 0;
    chk("drop1", 32'(drop_cnt), 1);
    chk("drop1_valid", 32'(bus.TDC_Ovalid), 1);
    bus.TDC_Oready = 1;
    drain("drop_send");
    cmp_stream("drop_send");
    fstart();
    hit(15'd77, 16'h0101, 0);
    frame_start = 1;
    fend();
    frame_start = 0;
    chk("drop2", 32'(drop_cnt), 2);
    chk("coinc_valid", 32'(bus.TDC_Ovalid), 1);
    drain("coinc");
    cmp_stream("coinc");

    // Empty frame.
    fstart();
    fend();
`ifdef TDC_EMPTY_FRAME_EN
    chk("empty_valid", 32'(bus.TDC_Ovalid), 1);
    chk("empty_irq", 32'(TDC_INT), 1);
    chk("empty_last", 32'(bus.TDC_Olast), 1);
    chk("empty_num", 32'(bus.TDC_Onum), 0);
    chk("empty_data", 32'(bus.TDC_Odata), 0);
`else
    for (int i = 0; i < 3; i++) begin
      chk("empty_novalid", 32'(bus.TDC_Ovalid), 0);
      chk("empty_noirq", 32'(TDC_INT), 0);
      step();
    end
`endif
    drain("empty");
    cmp_stream("empty");

    // Reset during beat 2 of 3.
    fstart();
    hit(15'd11, 16'h0001, 0);
    hit(15'd22, 16'h0003, 0);
    hit(15'd33, 16'h0007, 0);
    fend();
    step();
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(bus.TDC_Ovalid), 0);
    chk("mid_rst_irq", 32'(TDC_INT), 0);
    chk("mid_rst_data", 32'(bus.TDC_Odata), 0);
    chk("mid_rst_int", 32'(bus.TDC_Oint), 0);
    chk("mid_rst_num", 32'(bus.TDC_Onum), 0);
    chk("mid_rst_last", 32'(bus.TDC_Olast), 0);
    chk("mid_rst_drop", 32'(drop_cnt), 0);
    step();
    rst_n = 1;
    step();
    chk("mid_rst_beats", got_q.size(), 1);
    got_q.delete();
    exp_q.delete();
    fstart();
    hit(15'd321, 16'h00FF, 0);
    fend();
    drain("post_rst");
    cmp_stream("post_rst");

    // Randomised frames with random backpressure.
    rnd_ready = 1;
    for (int f = 0; f < 40; f++) begin
      n     = $urandom_range(0, 5);
      co    = 1'($urandom_range(0, 1));
      range = 15'($urandom_range(0, 32767));
      fstart();
      for (int i = 0; i < n; i++) begin
        hit(15'($urandom), 16'($urandom), co && (i == n - 1));
        if ($urandom_range(0, 3) == 0) step();
      end
      if (!(co && n > 0)) fend();
      drain("rnd");
    end
    rnd_ready = 0;
    bus.TDC_Oready = 1;
    cmp_stream("rnd");
    chk("rnd_drop", 32'(drop_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdc_hit_packer.md
# tdc_hit_packer

Parametrised multi-hit result buffer and stream packer for the TDC frame path. It captures up to MAX_HITS time-of-flight results per measurement frame, together with each hit's SPAD-enable snapshot. Each snapshot is reduced to an intensity code. When the frame closes, the stored hits go out as a one-beat-per-hit ready/valid stream with count and last markers. It sits between the TDC decode/coarse-count logic (hit producer) and the core-logic stream consumer, in the 250 MHz logic domain.

## Interface
Parameters:
- MAX_HITS, 3, hits stored per frame (≥1)
- TOF_W, 15, time-of-flight width
- SPAD_N, 16, SPAD enable vector width
- INT_W, 4, intensity code width
- NUM_W, $clog2(MAX_HITS+1), hit-count width

Ports:
- clk  in  1  logic clock; single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- frame_start  in  1  pulse; opens a frame
- frame_end  in  1  pulse; closes a frame
- range  in  TOF_W  max valid TOF; sampled with each hit
- hit_valid  in  1  hit strobe
- hit_tof  in  TOF_W  hit time-of-flight
- hit_spad  in  SPAD_N  SPAD enables for the hit
- TDC_Odata  out  TOF_W  beat TOF
- TDC_Oint  out  INT_W  beat intensity
- TDC_Onum  out  NUM_W  hits in the current frame; constant across the frame's beats
- TDC_Olast  out  1  final beat of the frame
- TDC_Ovalid  out  1  beat valid
- TDC_Oready  in  1  consumer ready
- TDC_INT  out  1  frame-pending interrupt
- drop_cnt  out  8  saturating count of dropped frames

## Operation
- States: IDLE, CAPTURE, SEND.
- IDLE:
  - frame_start → CAPTURE; hit count cleared.
  - hit_valid and frame_end are ignored.
- CAPTURE, hit_valid with count < MAX_HITS:
  - Write slot[count]. TOF is stored as hit_tof if hit_tof ≤ range, else all-ones.
  - Intensity is stored as popcount(hit_spad), saturated to 2^INT_W−1.
  - count increments.
- CAPTURE, hit_valid with count = MAX_HITS: hit discarded; count holds.
- CAPTURE, hit_valid together with frame_end: the hit is stored first, then the frame closes.
- CAPTURE, frame_start without frame_end: restart; count cleared.
- CAPTURE, frame_start together with frame_end: frame_end wins; drop_cnt increments.
- CAPTURE, frame_end with count ≥ 1: → SEND; beat index cleared.
- SEND:
  - Presents slot[beat]; TDC_Onum = count; TDC_Olast = (beat = count−1).
  - On TDC_Ovalid & TDC_Oready, beat increments. On the last beat's handshake → IDLE.
  - hit_valid and frame_end are ignored.
  - frame_start → that frame is dropped and drop_cnt increments; state is not changed.
- drop_cnt saturates at 255 and clears only on reset.
- Handshake rules:
  - TDC_Ovalid never drops without a handshake.
  - Data, int, num and last are stable while valid is high and ready is low.
- TDC_INT rises when entering SEND and falls the cycle after the last handshake.

## Timing
- Reset: all outputs 0; state IDLE; slots 0; drop_cnt 0.
- Hit latency: a hit presented at cycle t is stored at t+1.
- Frame latency:
  - frame_end at t → TDC_Ovalid = 1 and TDC_INT = 1 at t+1.
  - With TDC_Oready held high, beats occur at t+1…t+count and the block is back in IDLE at t+count+1.
- Throughput: 1 beat/cycle; no bubbles between beats.
- Reset mid-SEND aborts the stream immediately; valid drops asynchronously and no last beat is sent.

## Configuration
- TDC_EMPTY_FRAME_EN defined:
  - frame_end with count = 0 → SEND, emitting exactly one beat: data 0, int 0, num 0, last 1.
  - TDC_INT behaves as for a normal frame.
- Undefined: frame_end with count = 0 → IDLE directly; no beat is emitted and TDC_INT stays 0.

## Structure
- Shared package tdc_pkg:
  - state encoding (IDLE/CAPTURE/SEND)
  - TOF overflow constant (all-ones of TOF_W)
  - default TOF_W/SPAD_N/INT_W
- Sub-module tdc_popcount: parametrised SPAD_N → saturated INT_W combinational popcount.
- Slot storage is a register array.

## Test plan
- Two-hit frame: frame_start; hits (100, 16'h000F) and (200, 16'hFFFF); frame_end; ready high → beats (100, 4, num 2, last 0) then (200, 15, num 2, last 1); TDC_INT high 2 cycles.
- Overflow and range: range 500; hits 10, 600, 20, 30 → 3 beats: 10, 7FFF, 20; the fourth hit is discarded.
- Backpressure: 3-hit frame; ready toggles 1,0,0,1,1 → each beat stays stable while stalled; exactly 3 handshakes; last only on the third.
- Drop and coincidence:
  - frame_start during SEND → drop_cnt = 1; stream unaffected.
  - frame_start with frame_end in CAPTURE → drop_cnt = 2.
- Empty frame: frame_start, frame_end, no hits → with the macro, one beat (0, 0, num 0, last 1); without it, no valid and TDC_INT stays 0.
- Reset mid-stream: rst_n low during beat 2 of 3 → all outputs 0 at once; a subsequent 1-hit frame streams correctly.
